// File: rtl/accum_decoder_if.sv
// Handshake bundle between the running-sum producer, the operand consumer and accum_decoder.
interface accum_decoder_if;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_carry;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       clr_err;
  logic       err;
  logic [7:0] err_cnt;

  // Decoder side.
  modport slave (
    input  in_valid,
    input  in_sum,
    input  in_carry,
    input  out_ready,
    input  clr_err,
    output in_ready,
    output out_valid,
    output out_data,
    output err,
    output err_cnt
  );

  // Producer/consumer side.
  modport master (
    output in_valid,
    output in_sum,
    output in_carry,
    output out_ready,
    output clr_err,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  err,
    input  err_cnt
  );
endinterface

// File: rtl/accum_decoder.sv
// Recovers accumulator operands from successive running sums, checks the accumulator carry
// against the wrap implied by the sums, and queues operands in a small FIFO.
module accum_decoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input logic            clk,
  input logic            rst,
  accum_decoder_if.slave bus_io
);

  localparam int unsigned    PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0]  FullCnt   = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic           StopOnErr = (STOP_ON_ERR != 0);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [3:0]      prev_sum_q, prev_sum_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [3:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;

  logic       full, empty, in_ready, push, pop;
  logic       exp_carry, mismatch;
  logic [3:0] delta;

  assign full      = (cnt_q == FullCnt);
  assign empty     = (cnt_q == '0);
  assign in_ready  = !full && (state_q != StHalt);
  assign push      = bus_io.in_valid && in_ready;
  assign pop       = !empty && bus_io.out_ready;
  // Sum decreasing means the accumulator wrapped, so a carry must have been produced.
  assign exp_carry = (bus_io.in_sum < prev_sum_q);
  assign mismatch  = push && (exp_carry != bus_io.in_carry);
  assign delta     = bus_io.in_sum - prev_sum_q;

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = !empty;
  assign bus_io.out_data  = mem_q[rd_ptr_q];
  assign bus_io.err       = err_q;
  assign bus_io.err_cnt   = err_cnt_q;

  // Next-state for decoder FSM, error tracking and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    prev_sum_d = prev_sum_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (push) begin
      prev_sum_d = bus_io.in_sum;
      wr_ptr_d   = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A new mismatch outranks a coincident clear.
    if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (bus_io.clr_err) begin
      err_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (push) begin
          state_d = (mismatch && StopOnErr) ? StHalt : StRun;
        end
      end
      StRun: begin
        if (mismatch && StopOnErr) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (bus_io.clr_err) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_sum_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_sum_q <= prev_sum_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; contents are meaningless once the occupancy is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= delta;
    end
  end

endmodule

// File: tb/tb_accum_decoder.sv
// Self-checking bench for accum_decoder: directed table, hand sequences and randomized traffic
// against a queue-based reference model.
module tb_accum_decoder;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  accum_decoder_if bus_a ();
  accum_decoder_if bus_b ();

  accum_decoder #(.DEPTH(Depth), .STOP_ON_ERR(1)) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .bus_io (bus_a)
  );

  accum_decoder #(.DEPTH(Depth), .STOP_ON_ERR(0)) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .bus_io (bus_b)
  );

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       c;
    logic       o;
    logic       clr;
    logic       eov;
    logic [3:0] eod;
    logic       eir;
    logic       eerr;
    logic [7:0] ecnt;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  int m_q[$];
  int m_prev = 0;
  bit m_err  = 1'b0;
  int m_cnt  = 0;
  bit m_halt = 1'b0;
  int got[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int s, input int c, input int o, input int clr,
                              input int eov, input int eod, input int eir, input int eerr,
                              input int ecnt);
    vec_t r;
    r.v = v[0]; r.s = s[3:0]; r.c = c[0]; r.o = o[0]; r.clr = clr[0];
    r.eov = eov[0]; r.eod = eod[3:0]; r.eir = eir[0]; r.eerr = eerr[0]; r.ecnt = ecnt[7:0];
    return r;
  endfunction

  task automatic drive(input bit v, input int s, input bit c, input bit o, input bit clr);
    bus_a.in_valid  = v;
    bus_a.in_sum    = 4'(s);
    bus_a.in_carry  = c;
    bus_a.out_ready = o;
    bus_a.clr_err   = clr;
  endtask

  // One clock on dut_a: advance the model by the rules and compare every output.
  task automatic tick();
    bit acc, pp, mism, clr, c, r;
    int s, d;
    acc  = bus_a.in_valid && (m_q.size() < Depth) && !m_halt;
    pp   = (m_q.size() > 0) && bus_a.out_ready;
    s    = int'(bus_a.in_sum);
    c    = bus_a.in_carry;
    clr  = bus_a.clr_err;
    r    = rst_a;
    mism = 1'b0;
    if (!r && bus_a.out_valid && bus_a.out_ready) got.push_back(int'(bus_a.out_data));
    @(posedge clk);
    #1;
    if (r) begin
      m_q.delete();
      m_prev = 0; m_err = 1'b0; m_cnt = 0; m_halt = 1'b0;
    end else begin
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        d = (s - m_prev) & 15;
        mism = ((s < m_prev) != c);
        m_q.push_back(d);
        m_prev = s;
      end
      if (mism) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_halt = 1'b1;
      end else if (clr) begin
        m_err  = 1'b0;
        m_halt = 1'b0;
      end
    end
    chk("model_out_valid", int'(bus_a.out_valid), int'(m_q.size() > 0));
    chk("model_in_ready", int'(bus_a.in_ready), int'((m_q.size() < Depth) && !m_halt));
    chk("model_err", int'(bus_a.err), int'(m_err));
    chk("model_err_cnt", int'(bus_a.err_cnt), m_cnt);
    if (m_q.size() > 0) chk("model_out_data", int'(bus_a.out_data), m_q[0]);
  endtask

  initial begin
    vec_t tbl[12];
    int   exp_d[$];
    int   s, prev_b;
    bit   c;

    // v s c o clr | ov od ir err cnt
    tbl[0]  = mk(1, 3, 0, 1, 0,  1,  3, 1, 0, 0);
    tbl[1]  = mk(1, 7, 0, 1, 0,  1,  4, 1, 0, 0);
    tbl[2]  = mk(1, 2, 1, 1, 0,  1, 11, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0,  0,  0, 1, 0, 0);
    tbl[4]  = mk(1, 9, 0, 1, 0,  1,  7, 1, 0, 0);
    tbl[5]  = mk(1, 4, 0, 0, 0,  1,  7, 0, 1, 1);
    tbl[6]  = mk(1, 5, 0, 1, 0,  1, 11, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 1, 1,  0,  0, 1, 0, 1);
    tbl[8]  = mk(1, 5, 0, 1, 0,  1,  1, 1, 0, 1);
    tbl[9]  = mk(1, 3, 0, 1, 1,  1, 14, 0, 1, 2);
    tbl[10] = mk(0, 0, 0, 1, 0,  0,  0, 0, 1, 2);
    tbl[11] = mk(0, 0, 0, 1, 1,  0,  0, 1, 0, 2);

    drive(0, 0, 0, 0, 0);
    bus_b.in_valid = 1'b0; bus_b.in_sum = 4'd0; bus_b.in_carry = 1'b0;
    bus_b.out_ready = 1'b0; bus_b.clr_err = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", int'(bus_a.out_valid), 0);
    chk("rst_in_ready", int'(bus_a.in_ready), 1);
    chk("rst_err", int'(bus_a.err), 0);
    chk("rst_err_cnt", int'(bus_a.err_cnt), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Directed vectors: basic decode, mismatch/halt/drain, clear coincident with mismatch.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, int'(tbl[i].s), tbl[i].c, tbl[i].o, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_out_valid", i), int'(bus_a.out_valid), int'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl%0d_out_data", i), int'(bus_a.out_data), int'(tbl[i].eod));
      chk($sformatf("tbl%0d_in_ready", i), int'(bus_a.in_ready), int'(tbl[i].eir));
      chk($sformatf("tbl%0d_err", i), int'(bus_a.err), int'(tbl[i].eerr));
      chk($sformatf("tbl%0d_err_cnt", i), int'(bus_a.err_cnt), int'(tbl[i].ecnt));
    end

    // Fill to full with the consumer stalled, hold a fifth sample, then drain in order.
    got.delete();
    drive(1, 4, 0, 0, 0);  tick(); chk("full1_in_ready", int'(bus_a.in_ready), 1);
    drive(1, 6, 0, 0, 0);  tick(); chk("full2_in_ready", int'(bus_a.in_ready), 1);
    drive(1, 9, 0, 0, 0);  tick(); chk("full3_in_ready", int'(bus_a.in_ready), 1);
    drive(1, 13, 0, 0, 0); tick(); chk("full4_in_ready", int'(bus_a.in_ready), 0);
    drive(1, 15, 0, 0, 0);
    tick(); chk("held_in_ready", int'(bus_a.in_ready), 0);
    tick(); chk("held_out_data", int'(bus_a.out_data), 1);
    drive(1, 15, 0, 1, 0);
    tick(); chk("nofall_in_ready", int'(bus_a.in_ready), 1);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("drain_count", got.size(), 5);
    exp_d = '{1, 2, 3, 4, 2};
    for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("drain%0d", i), got[i], exp_d[i]);

    // Reset with three entries queued and a sample offered.
    drive(1, 1, 1, 0, 0); tick();
    drive(1, 2, 0, 0, 0); tick();
    drive(1, 3, 0, 0, 0); tick();
    chk("pre_rst_out_valid", int'(bus_a.out_valid), 1);
    rst_a = 1'b1;
    drive(1, 9, 0, 1, 0);
    tick();
    chk("midrst_out_valid", int'(bus_a.out_valid), 0);
    chk("midrst_in_ready", int'(bus_a.in_ready), 1);
    chk("midrst_err_cnt", int'(bus_a.err_cnt), 0);
    rst_a = 1'b0;
    drive(1, 6, 0, 0, 0);
    tick();
    chk("post_rst_out_valid", int'(bus_a.out_valid), 1);
    chk("post_rst_out_data", int'(bus_a.out_data), 6);
    drive(0, 0, 0, 1, 0);
    tick();

    // Full throughput with well-formed carries.
    got.delete();
    exp_d.delete();
    s = 0;
    for (int i = 0; i < 200; i++) begin
      s = int'($urandom_range(15));
      c = (s < m_prev);
      exp_d.push_back((s - m_prev) & 15);
      drive(1, s, c, 1, 0);
      chk("tput_in_ready", int'(bus_a.in_ready), 1);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
    chk("tput_count", got.size(), 200);
    for (int i = 0; i < 200 && i < got.size(); i++) begin
      if (got[i] != exp_d[i]) chk($sformatf("tput_op%0d", i), got[i], exp_d[i]);
    end

    // Random mixed traffic with stalls, occasional mismatches, clears and resets.
    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(15));
      c = (s < m_prev);
      if ($urandom_range(15) == 0) c = !c;
      rst_a = ($urandom_range(99) == 0);
      drive(($urandom_range(3) != 0), s, c, ($urandom_range(2) != 0), ($urandom_range(7) == 0));
      tick();
    end
    rst_a = 1'b0;
    drive(0, 0, 0, 1, 1);
    tick();

    // STOP_ON_ERR=0: every sample mismatched, counter saturates, intake never halts.
    prev_b = 0;
    for (int i = 0; i < 300; i++) begin
      s = int'($urandom_range(15));
      bus_b.in_valid  = 1'b1;
      bus_b.in_sum    = 4'(s);
      bus_b.in_carry  = !(s < prev_b);
      bus_b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      prev_b = s;
      chk("nostop_in_ready", int'(bus_b.in_ready), 1);
      if (i == 99) chk("nostop_cnt100", int'(bus_b.err_cnt), 100);
    end
    bus_b.in_valid = 1'b0;
    chk("nostop_cnt_sat", int'(bus_b.err_cnt), 255);
    chk("nostop_err", int'(bus_b.err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_decoder.md
ACCUM_DECODER -- requirements
Module: accum_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO depth in entries (power of 2, >= 2).
REQ-002 SHALL have parameter STOP_ON_ERR, default 1, 1 = halt intake on carry mismatch.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  running-sum sample present.
REQ-006 SHALL have port in_sum  input  4  running sum from the 4-bit accumulator.
REQ-007 SHALL have port in_carry  input  1  accumulator carry accompanying in_sum.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_valid  output  1  recovered operand available.
REQ-010 SHALL have port out_data  output  4  recovered operand (head of FIFO).
REQ-011 SHALL have port out_ready  input  1  consumer pops head when out_valid and out_ready are both high.
REQ-012 SHALL have port clr_err  input  1  one-cycle pulse clearing error state.
REQ-013 SHALL have port err  output  1  sticky carry-mismatch flag.
REQ-014 SHALL have port err_cnt  output  8  carry-mismatch count, saturating at 255.

Function
REQ-015 SHALL hold prev_sum (4 bits), the last accepted in_sum; 0 after reset, matching the accumulator reset value.
REQ-016 On accept: delta = (in_sum - prev_sum) mod 16; prev_sum <= in_sum; delta pushed into FIFO.
REQ-017 Expected carry = 1 iff in_sum < prev_sum (unsigned); mismatch with in_carry SHALL set err and increment err_cnt (saturating) in the same cycle as the accept.
REQ-018 Delta SHALL be pushed even on mismatch.
REQ-019 FSM states: IDLE (no sample since reset), RUN, HALT.
REQ-020 IDLE -> RUN on first accept; RUN -> HALT on mismatch when STOP_ON_ERR=1; HALT -> RUN on clr_err; with STOP_ON_ERR=0, HALT is never entered.
REQ-021 in_ready = !fifo_full && state != HALT, combinational from registered state only.
REQ-022 out_valid = !fifo_empty; out_data = FIFO head; out_data SHALL be stable while out_valid && !out_ready.
REQ-023 Latency: operand accepted in cycle N SHALL appear on out_data at cycle N+1 when FIFO was empty.
REQ-024 Simultaneous push and pop SHALL be legal whenever not full; occupancy unchanged, order preserved.
REQ-025 No fall-through when full: in_ready low while full even if out_ready high.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH; occupancy tracked in log2(DEPTH)+1 bits.
REQ-027 clr_err SHALL clear err to 0 (err_cnt retained); clr_err coincident with a new mismatch SHALL leave err = 1 and state HALT.
REQ-028 In HALT, FIFO SHALL continue draining.

Reset
REQ-029 rst high at a clock edge SHALL set: state IDLE, prev_sum 0, FIFO empty, out_valid 0, err 0, err_cnt 0; in_ready 1 in the following cycle.
REQ-030 rst SHALL take priority over all inputs, including during an accept or pop; in-flight FIFO contents discarded.
REQ-031 out_data value while out_valid = 0 is don't-care.

Verification
REQ-032 Reset, then in_sum 3,7,2 with carry 0,0,1, out_ready=1 -> out_data 3,4,11, each one cycle after accept, err=0.
REQ-033 out_ready=0, push 5 samples (DEPTH=4) -> in_ready low after 4th, 5th held; raise out_ready -> 5 operands in order.
REQ-034 prev_sum=9, in_sum=4, carry=0 -> delta 11 pushed, err=1, err_cnt=1, state HALT, in_ready=0; clr_err -> in_ready=1.
REQ-035 STOP_ON_ERR=0, 300 mismatched samples -> err_cnt saturates at 255, in_ready never drops for error.
REQ-036 rst asserted with 3 entries queued and in_valid high -> next cycle out_valid=0, prev_sum=0; in_sum 6 then yields out_data 6.
REQ-037 Continuous in_valid/out_ready at full throughput, random in_sum -> one operand per cycle, no loss, matches reference model.
